// File: rtl/fft8_bin_streamer_if.sv
// Valid/ready bin stream carrying one complex bin and its squared magnitude per beat.
interface fft8_bin_streamer_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
);
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         out_index;
    logic signed [DATA_W-1:0] out_real;
    logic signed [DATA_W-1:0] out_imag;
    logic [2*DATA_W-1:0]      out_mag2;
    logic                     out_last;

    modport master (
        output out_valid, out_index, out_real, out_imag, out_mag2, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_index, out_real, out_imag, out_mag2, out_last,
        output out_ready
    );
endinterface

// File: rtl/fft8_bin_streamer.sv
// Captures one fft8 frame on the rising completion strobe and streams its bins
// in order, each with real^2 + imag^2, over a valid/ready interface.
module fft8_bin_streamer #(
    parameter int          DATA_W = 16,
    parameter int unsigned N_BINS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_stb,
    input  logic signed [DATA_W-1:0] in1_real,
    input  logic signed [DATA_W-1:0] in1_imag,
    input  logic signed [DATA_W-1:0] in2_real,
    input  logic signed [DATA_W-1:0] in2_imag,
    input  logic signed [DATA_W-1:0] in3_real,
    input  logic signed [DATA_W-1:0] in3_imag,
    input  logic signed [DATA_W-1:0] in4_real,
    input  logic signed [DATA_W-1:0] in4_imag,
    input  logic signed [DATA_W-1:0] in5_real,
    input  logic signed [DATA_W-1:0] in5_imag,
    input  logic signed [DATA_W-1:0] in6_real,
    input  logic signed [DATA_W-1:0] in6_imag,
    input  logic signed [DATA_W-1:0] in7_real,
    input  logic signed [DATA_W-1:0] in7_imag,
    input  logic signed [DATA_W-1:0] in8_real,
    input  logic signed [DATA_W-1:0] in8_imag,
    fft8_bin_streamer_if.master      stream,
    output logic                     busy,
    output logic                     overrun
);
    localparam int IDX_W = $clog2(N_BINS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                   state;
    logic                     in_stb_d;
    logic                     frame_start;
    logic                     capture;
    logic [IDX_W-1:0]         idx_q;
    logic [IDX_W-1:0]         next_idx;
    logic                     valid_q;
    logic                     last_q;
    logic signed [DATA_W-1:0] real_q;
    logic signed [DATA_W-1:0] imag_q;
    logic [2*DATA_W-1:0]      mag2_q;

    logic signed [DATA_W-1:0] in_re  [N_BINS];
    logic signed [DATA_W-1:0] in_im  [N_BINS];
    logic signed [DATA_W-1:0] buf_re [N_BINS];
    logic signed [DATA_W-1:0] buf_im [N_BINS];

    // Both squares are non-negative and <= 2^30, so the unsigned sum never wraps.
    function automatic logic [2*DATA_W-1:0] mag2_of(
        input logic signed [DATA_W-1:0] re,
        input logic signed [DATA_W-1:0] im
    );
        logic signed [2*DATA_W-1:0] re_x;
        logic signed [2*DATA_W-1:0] im_x;
        logic signed [2*DATA_W-1:0] pr;
        logic signed [2*DATA_W-1:0] pi;
        re_x = {{DATA_W{re[DATA_W-1]}}, re};
        im_x = {{DATA_W{im[DATA_W-1]}}, im};
        pr   = re_x * re_x;
        pi   = im_x * im_x;
        return $unsigned(pr) + $unsigned(pi);
    endfunction

    always_comb begin
        in_re[0] = in1_real;  in_im[0] = in1_imag;
        in_re[1] = in2_real;  in_im[1] = in2_imag;
        in_re[2] = in3_real;  in_im[2] = in3_imag;
        in_re[3] = in4_real;  in_im[3] = in4_imag;
        in_re[4] = in5_real;  in_im[4] = in5_imag;
        in_re[5] = in6_real;  in_im[5] = in6_imag;
        in_re[6] = in7_real;  in_im[6] = in7_imag;
        in_re[7] = in8_real;  in_im[7] = in8_imag;
    end

    assign frame_start = in_stb && !in_stb_d;
    assign capture     = frame_start && (state == IDLE);
    assign next_idx    = idx_q + IDX_W'(1);

    // Frame buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int unsigned i = 0; i < N_BINS; i++) begin
                buf_re[i] <= in_re[i];
                buf_im[i] <= in_im[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            in_stb_d <= 1'b1;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            real_q   <= '0;
            imag_q   <= '0;
            mag2_q   <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            in_stb_d <= in_stb;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        real_q  <= in_re[0];
                        imag_q  <= in_im[0];
                        mag2_q  <= mag2_of(in_re[0], in_im[0]);
                        idx_q   <= '0;
                        last_q  <= (LAST_IDX == '0);
                        valid_q <= 1'b1;
                        busy    <= 1'b1;
                        state   <= STREAM;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                STREAM: begin
                    if (frame_start) overrun <= 1'b1;
                    if (stream.out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            idx_q  <= next_idx;
                            real_q <= buf_re[next_idx];
                            imag_q <= buf_im[next_idx];
                            mag2_q <= mag2_of(buf_re[next_idx], buf_im[next_idx]);
                            last_q <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stream.out_valid = valid_q;
    assign stream.out_index = idx_q;
    assign stream.out_real  = real_q;
    assign stream.out_imag  = imag_q;
    assign stream.out_mag2  = mag2_q;
    assign stream.out_last  = last_q;
endmodule

// File: doc/fft8_bin_streamer.md
Name: fft8_bin_streamer

Overview:
- Downstream stage of the fft8 core: captures the 8 parallel complex bins when the core's completion strobe goes high.
- Streams the bins out one per beat, in bin order, over a valid/ready interface.
- Each beat carries the bin's real, imag and 32-bit magnitude-squared, for the spectrum/peak-detect logic that follows.

Parameters:
- DATA_W, 16: width of each real/imag word (signed, Q8.8 as produced by fft8).
- N_BINS, 8: bins per frame; index width is clog2(N_BINS).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets immediately; release is synchronous to clk).
- in_stb  in  1  fft8 out_stb; level signal that stays high after the frame completes.
- inK_real  in  DATA_W  signed real part of bin K, K=1..8 (fft8 outK_real).
- inK_imag  in  DATA_W  signed imag part of bin K, K=1..8 (fft8 outK_imag).
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_index  out  3  bin number, 0..7 (0 = inp1 bin).
- out_real  out  DATA_W  bin real part.
- out_imag  out  DATA_W  bin imag part.
- out_mag2  out  2*DATA_W  unsigned real^2 + imag^2.
- out_last  out  1  high with the index-7 beat.
- busy  out  1  high while a frame is held or streaming.
- overrun  out  1  sticky: a new frame arrived while busy.

Behaviour:
- Reset (rst=0, async): out_valid=0, out_index=0, out_real=0, out_imag=0, out_mag2=0, out_last=0, busy=0, overrun=0, state=IDLE, in_stb_d=1, frame buffer contents don't-care.
  - in_stb_d resets to 1 so a strobe already high at reset release does not trigger a capture.
- Frame start = in_stb=1 and in_stb_d=0 at a clock edge; in_stb_d <= in_stb every cycle.
- States: IDLE and STREAM.
- IDLE, frame start:
  - latch all 16 input words into the frame buffer;
  - load output registers with bin 0 (in1_real, in1_imag and its mag2), out_index=0;
  - set out_valid=1, busy=1, go to STREAM.
  - Latency: outputs are valid the cycle after the edge at which the rising strobe is sampled.
- IDLE, no frame start: hold; out_valid=0.
- STREAM, out_valid=1 and out_ready=0: all outputs hold stable (no change in data, index or last).
- STREAM, out_valid=1 and out_ready=1 at an edge:
  - if out_index<7: out_index+1; load that bin from the buffer and its mag2; out_last=1 when the new index is 7.
  - if out_index=7: out_valid=0, out_last=0, busy=0, go to IDLE.
    - out_real, out_imag, out_mag2 and out_index keep their last values.
- Minimum frame turnaround: a frame start in the same cycle as the index-7 handshake is an overrun. A frame start one cycle later is captured.
- Frame start while in STREAM:
  - set overrun=1; ignore the new data; the current stream continues untouched.
  - overrun is cleared only by reset.
- in_stb held high for many cycles yields exactly one capture; it must return low before the next frame start.
- mag2 arithmetic:
  - both products are signed DATA_W x DATA_W, each non-negative and at most 2^30;
  - the sum is at most 2^31 and is carried as unsigned 2*DATA_W bits, with no saturation and no overflow;
  - mag2 is registered together with real/imag, so all three always belong to the same bin.
- Reset mid-stream aborts the frame immediately, with no partial beats after release.
- out_valid never drops without a handshake, except on reset.
- Implementation: 16-entry buffer, 3-bit index counter, registered outputs; about 150-250 lines of RTL.

Test Plan:
- Impulse frame: all inK_real=16'sd256, inK_imag=0, out_ready=1, in_stb 0->1.
  - Next cycle out_valid=1, index 0; then 8 consecutive beats, each with real=256, imag=0, mag2=65536.
  - out_last only on index 7; out_valid=0 and busy=0 the cycle after.
- Backpressure: distinct values per bin (inK_real=K*100, inK_imag=-K), out_ready=0 for 3 cycles when index=2.
  - Index 2 holds real=300, imag=-3, mag2=90009 for all stall cycles; no beat lost or duplicated.
- Extremes: in1_real=in1_imag=-32768 -> mag2=0x80000000. in2_real=32767, in2_imag=0 -> mag2=0x3FFF0001.
- Overrun: during streaming, drop in_stb for 1 cycle and re-raise it with different data.
  - overrun=1 and stays 1; the streamed beats are all from the first frame.
  - A later frame start in IDLE is captured normally.
- Strobe level/reset:
  - Hold in_stb=1 for 40 cycles: exactly 8 beats.
  - Assert rst=0 at index 4: out_valid=0 immediately (async). After release with in_stb still high, there is no capture until in_stb toggles 0->1.
